// File: rtl/inv_trans_divider.sv
// Inverse transmission 1/t (Q0.8 in, Q2.12 out, saturated) via a radix-2
// restoring divider, one quotient bit per clock; a pixel tag rides along.
module inv_trans_divider #(
  parameter int T_MIN = 64,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_trans,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [13:0]      out_inv,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_clamped
);

  localparam logic [7:0]  TMIN     = T_MIN[7:0];
  localparam logic [20:0] DIVIDEND = 21'h100000;
  localparam logic [13:0] INV_MAX  = 14'h3fff;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_div;
  logic [8:0]       r_rem;
  logic [20:0]      r_q;
  logic [4:0]       r_cnt;
  logic             r_clamp;
  logic [TAG_W-1:0] r_tag;
  logic [13:0]      r_inv;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_clamped;

  logic        w_accept, w_release, w_last, w_ge, w_sat, w_clamp_in;
  logic [9:0]  w_rem_sh;
  logic [8:0]  w_rem_nxt;
  logic [20:0] w_q_nxt;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_inv     = r_inv;
  assign out_tag     = r_out_tag;
  assign out_clamped = r_out_clamped;

  assign w_accept   = in_valid & in_ready;
  assign w_release  = out_valid & out_ready;
  assign w_last     = (r_state == S_DIV) && (r_cnt == 5'd0);
  assign w_clamp_in = (in_trans < TMIN);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    w_rem_sh  = {r_rem, DIVIDEND[r_cnt]};
    w_ge      = (w_rem_sh >= {2'b00, r_div});
    w_rem_nxt = w_ge ? 9'(w_rem_sh - {2'b00, r_div}) : w_rem_sh[8:0];
    w_q_nxt   = r_q;
    w_q_nxt[r_cnt] = w_ge;
    w_sat     = |w_q_nxt[20:14];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_DIV;
      S_DIV:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (w_release) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_rem         <= '0;
      r_q           <= '0;
      r_cnt         <= '0;
      r_clamp       <= 1'b0;
      r_tag         <= '0;
      r_inv         <= '0;
      r_out_tag     <= '0;
      r_out_clamped <= 1'b0;
    end else if (w_accept) begin
      r_div   <= w_clamp_in ? TMIN : in_trans;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= 5'd20;
      r_clamp <= w_clamp_in;
      r_tag   <= in_tag;
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_nxt;
      r_q   <= w_q_nxt;
      r_cnt <= r_cnt - 5'd1;
      // Final bit is folded in here so the result registers load on entry to DONE.
      if (w_last) begin
        r_inv         <= w_sat ? INV_MAX : w_q_nxt[13:0];
        r_out_tag     <= r_tag;
        r_out_clamped <= r_clamp | w_sat;
      end
    end
  end

endmodule

// File: tb/tb_inv_trans_divider.sv
// Scoreboard bench for inv_trans_divider: directed operands with hand-computed
// inverses; a negedge monitor checks data, latency and hold length.
module tb_inv_trans_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_trans = '0;
  logic [23:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [13:0] out_inv;
  logic [23:0] out_tag;
  logic        out_clamped;

  inv_trans_divider #(.T_MIN(64), .TAG_W(24)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_trans(in_trans), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_inv(out_inv),
    .out_tag(out_tag), .out_clamped(out_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] inv;
    logic [23:0] tag;
    logic        clamp;
    int          acc;
    int          hold;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: one sample per cycle on the falling edge.
  initial begin
    bit prev_v = 1'b0;
    int hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        hold_cnt = 0;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            if (!prev_v) chk("unexpected_result", 1, 0);
          end else begin
            if (!prev_v) chk("latency", cyc - sb[0].acc, 21);
            hold_cnt++;
            chk("out_inv", out_inv, sb[0].inv);
            chk("out_tag", out_tag, sb[0].tag);
            chk("out_clamped", out_clamped, sb[0].clamp);
            chk("in_ready_in_done", in_ready, 0);
            if (out_ready) begin
              chk("hold_cycles", hold_cnt, sb[0].hold);
              void'(sb.pop_front());
              hold_cnt = 0;
            end
          end
        end
        prev_v = out_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand and wait (bounded) for its accept edge.
  task automatic send(input logic [7:0] t, input logic [23:0] tag,
                      input logic [13:0] e_inv, input logic e_clamp,
                      input int hold, input bit push, output int acc);
    int w = 0;
    in_valid = 1'b1;
    in_trans = t;
    in_tag   = tag;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      acc = -1;
    end else begin
      tick();
      acc = cyc;
      if (push) sb.push_back('{e_inv, tag, e_clamp, acc, hold});
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 200) begin
      tick();
      w++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int a0, a1, a2, w;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inv", out_inv, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_clamped", out_clamped, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Single operands.
    send(8'd128, 24'hA1B2C3, 14'd8192, 1'b0, 1, 1'b1, a0);
    in_valid = 1'b0; drain();
    send(8'd255, 24'h000011, 14'd4112, 1'b0, 1, 1'b1, a0);
    in_valid = 1'b0; drain();
    send(8'd200, 24'h000022, 14'd5242, 1'b0, 1, 1'b1, a0);
    in_valid = 1'b0; drain();
    send(8'd64, 24'h000033, 14'd16383, 1'b1, 1, 1'b1, a0);
    in_valid = 1'b0; drain();
    send(8'd10, 24'h000044, 14'd16383, 1'b1, 1, 1'b1, a0);
    in_valid = 1'b0; drain();
    send(8'd0, 24'h000055, 14'd16383, 1'b1, 1, 1'b1, a0);
    in_valid = 1'b0; drain();

    // Backpressure: ready low for 5 cycles after valid rises.
    out_ready = 1'b0;
    send(8'd128, 24'h0BEEF0, 14'd8192, 1'b0, 6, 1'b1, a0);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 100) begin
      tick();
      w++;
    end
    chk("bp_valid_seen", out_valid, 1);
    repeat (5) tick();
    out_ready = 1'b1;
    tick();
    chk("bp_out_valid_dropped", out_valid, 0);
    chk("bp_in_ready_rises", in_ready, 1);
    drain();

    // Back-to-back with in_valid held high.
    send(8'd255, 24'h111111, 14'd4112, 1'b0, 1, 1'b1, a0);
    send(8'd128, 24'h222222, 14'd8192, 1'b0, 1, 1'b1, a1);
    send(8'd200, 24'h333333, 14'd5242, 1'b0, 1, 1'b1, a2);
    in_valid = 1'b0;
    chk("b2b_spacing_1", a1 - a0, 23);
    chk("b2b_spacing_2", a2 - a1, 23);
    drain();

    // Reset mid-divide: nothing is pushed, so any emitted result is flagged.
    send(8'd10, 24'hDEAD00, 14'd0, 1'b0, 1, 1'b0, a0);
    in_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    send(8'd128, 24'h5A5A5A, 14'd8192, 1'b0, 1, 1'b1, a0);
    in_valid = 1'b0;
    drain();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
